// File: rtl/md_hazard_controller.sv
// Multiply/divide unit (HI/LO, multi-cycle busy sequencing) and the D-stage stall
// decision covering Tuse/Tnew data hazards and MD structural hazards.
module md_hazard_controller #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op_E,
   input  logic [31:0] rs_val_E,
   input  logic [31:0] rt_val_E,
   input  logic        md_use_D,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [1:0]  tuse_rs,
   input  logic [1:0]  tuse_rt,
   input  logic [4:0]  a3_E,
   input  logic [4:0]  a3_M,
   input  logic [1:0]  tnew_E,
   input  logic [1:0]  tnew_M,
   input  logic        regwrite_E,
   input  logic        regwrite_M,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  counter;
   logic [2:0]        op_p0;
   logic [31:0]       rs_p0;
   logic [31:0]       rt_p0;
   logic [63:0]       result;
   logic              res_wr;
   logic              md_start;
   logic              stall_rs;
   logic              stall_rt;
   logic              stall_md;

   function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
      return ax * bx;
   endfunction

   function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows
   // the dividend; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
   function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
      a_mag = a[31] ? (~a + 32'd1) : a;
      b_mag = b[31] ? (~b + 32'd1) : b;
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q     = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
      r     = a[31] ? (~r_mag + 32'd1) : r_mag;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
      return {a % b, a / b};
   endfunction

   assign md_start = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);

   // Result comes only from the operands latched at the start of the operation.
   always_comb begin
      result = 64'd0;
      res_wr = 1'b1;
      case (op_p0)
         OP_MULT:  result = mul_signed(rs_p0, rt_p0);
         OP_MULTU: result = mul_unsigned(rs_p0, rt_p0);
         OP_DIV: begin
            result = div_signed(rs_p0, rt_p0);
            res_wr = (rt_p0 != 32'd0);
         end
         OP_DIVU: begin
            result = div_unsigned(rs_p0, rt_p0);
            res_wr = (rt_p0 != 32'd0);
         end
         default: res_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         op_p0   <= 3'd0;
         rs_p0   <= 32'd0;
         rt_p0   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (md_start) begin
                  op_p0   <= md_op_E;
                  rs_p0   <= rs_val_E;
                  rt_p0   <= rt_val_E;
                  counter <= (md_op_E == OP_MULT || md_op_E == OP_MULTU) ?
                             CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state   <= RUN;
                  busy    <= 1'b1;
               end else if (md_op_E == OP_MTHI) begin
                  hi <= rs_val_E;
               end else if (md_op_E == OP_MTLO) begin
                  lo <= rs_val_E;
               end
            end
            RUN: begin
               counter <= counter - CNT_W'(1);
               if (counter == CNT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (res_wr) begin
                     {hi, lo} <= result;
                  end
               end
            end
         endcase
      end
   end

   assign stall_rs = (a1 != 5'd0) &&
                     ((regwrite_E && (a1 == a3_E) && (tuse_rs < tnew_E)) ||
                      (regwrite_M && (a1 == a3_M) && (tuse_rs < tnew_M)));
   assign stall_rt = (a2 != 5'd0) &&
                     ((regwrite_E && (a2 == a3_E) && (tuse_rt < tnew_E)) ||
                      (regwrite_M && (a2 == a3_M) && (tuse_rt < tnew_M)));
   assign stall_md = md_use_D && (busy || md_start);

   // Forced low during reset so the pipeline never sees undriven hazard inputs.
   assign stall = !reset && (stall_rs || stall_rt || stall_md);

endmodule

// File: tb/tb_md_hazard_controller.sv
// Self-checking bench for md_hazard_controller: hazard vector table, hand-written MD
// sequences and a randomized run against a cycle-indexed behavioural model.
module tb_md_hazard_controller;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  md_op_E;
   logic [31:0] rs_val_E, rt_val_E;
   logic        md_use_D;
   logic [4:0]  a1, a2, a3_E, a3_M;
   logic [1:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
   logic        regwrite_E, regwrite_M;
   logic [31:0] hi, lo;
   logic        busy, stall;

   always #5 clk = ~clk;

   md_hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_val_E(rs_val_E), .rt_val_E(rt_val_E),
      .md_use_D(md_use_D), .a1(a1), .a2(a2), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
      .a3_E(a3_E), .a3_M(a3_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
      .regwrite_E(regwrite_E), .regwrite_M(regwrite_M),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model: an operation started in cycle m_start is busy in (m_start, m_start+m_len].
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   bit          p_wr = 1'b0;
   int          m_start = -1;
   int          m_len = 0;

   typedef struct {
      logic [4:0] a1, a2;
      logic [1:0] tu_rs, tu_rt;
      logic [4:0] a3e, a3m;
      logic [1:0] tne, tnm;
      logic       rwe, rwm, mduse;
      logic [2:0] op;
      logic       exp;
   } vec_t;

   vec_t vt[10];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_busy();
      return (m_start >= 0) && (cyc > m_start) && (cyc <= m_start + m_len);
   endfunction

   function automatic bit haz(logic [4:0] a, logic [1:0] tu);
      bit s = 1'b0;
      if (a != 5'd0) begin
         if (regwrite_E && a == a3_E && tu < tnew_E) s = 1'b1;
         if (regwrite_M && a == a3_M && tu < tnew_M) s = 1'b1;
      end
      return s;
   endfunction

   function automatic bit m_stall();
      if (reset) return 1'b0;
      return haz(a1, tuse_rs) || haz(a2, tuse_rt) ||
             (md_use_D && (m_busy() || (md_op_E >= 3'd1 && md_op_E <= 3'd4)));
   endfunction

   task automatic compute(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      longint          p;
      longint unsigned pu;
      int              sa, sb;
      p_wr = 1'b1;
      sa = a;
      sb = b;
      case (op)
         3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {p_hi, p_lo} = p; end
         3'd2: begin pu = {32'd0, a} * {32'd0, b}; {p_hi, p_lo} = pu; end
         3'd3: begin
            if (b == 32'd0) p_wr = 1'b0;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin p_lo = a; p_hi = 32'd0; end
            else begin p_lo = sa / sb; p_hi = sa % sb; end
         end
         default: begin
            if (b == 32'd0) p_wr = 1'b0;
            else begin p_lo = a / b; p_hi = a % b; end
         end
      endcase
   endtask

   task automatic model_edge();
      if (reset) begin
         m_hi = 32'd0; m_lo = 32'd0; m_start = -1; p_wr = 1'b0;
      end else if (m_start >= 0) begin
         if (cyc == m_start + m_len) begin
            if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            m_start = -1;
         end
      end else begin
         case (md_op_E)
            3'd1, 3'd2, 3'd3, 3'd4: begin
               m_start = cyc;
               m_len   = (md_op_E <= 3'd2) ? MULT_N : DIV_N;
               compute(md_op_E, rs_val_E, rt_val_E);
            end
            3'd5: m_hi = rs_val_E;
            3'd6: m_lo = rs_val_E;
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", 32'(busy), 32'(m_busy()));
      check("stall", 32'(stall), 32'(m_stall()));
   endtask

   // Checks the current (settled) cycle, advances the model and the clock.
   task automatic tick();
      compare_all();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(logic [2:0] op, logic [31:0] rs, logic [31:0] rt, logic use_d);
      md_op_E = op; rs_val_E = rs; rt_val_E = rt; md_use_D = use_d;
      #1;
   endtask

   task automatic clear_hazard();
      a1 = 0; a2 = 0; a3_E = 0; a3_M = 0; tuse_rs = 2'd3; tuse_rt = 2'd3;
      tnew_E = 0; tnew_M = 0; regwrite_E = 0; regwrite_M = 0;
   endtask

   // Start an op, then run n idle cycles checking busy each one.
   task automatic run_op(string name, logic [2:0] op, logic [31:0] rs, logic [31:0] rt, int n);
      drive(op, rs, rt, 1'b0);
      check({name, "_idle_at_start"}, 32'(busy), 32'd0);
      tick();
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < n; i++) begin
         check({name, "_busy"}, 32'(busy), 32'd1);
         tick();
      end
      check({name, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners[6];
      corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd7};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      reset = 1'b1;
      clear_hazard();
      md_op_E = 0; rs_val_E = 0; rt_val_E = 0; md_use_D = 0;
      @(posedge clk);
      #1;
      tick();
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      tick();
      reset = 1'b0;
      #1;

      // a1 a2 tu_rs tu_rt a3e a3m tne tnm rwe rwm mduse op exp
      vt[0] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
      vt[1] = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      vt[2] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 5'd5, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
      vt[3] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 5'd5, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      vt[4] = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
      vt[5] = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      vt[6] = '{5'd0, 5'd7, 2'd3, 2'd3, 5'd7, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      vt[7] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd6, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      vt[8] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
      vt[9] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0};
      foreach (vt[i]) begin
         a1 = vt[i].a1; a2 = vt[i].a2; tuse_rs = vt[i].tu_rs; tuse_rt = vt[i].tu_rt;
         a3_E = vt[i].a3e; a3_M = vt[i].a3m; tnew_E = vt[i].tne; tnew_M = vt[i].tnm;
         regwrite_E = vt[i].rwe; regwrite_M = vt[i].rwm;
         drive(vt[i].op, 32'd0, 32'd0, vt[i].mduse);
         check($sformatf("hazard_vec%0d", i), 32'(stall), 32'(vt[i].exp));
         tick();
      end
      clear_hazard();

      // mult with an MD instruction waiting in D
      drive(3'd1, 32'd3, 32'hFFFFFFFC, 1'b1);
      check("mult_stall_start", 32'(stall), 32'd1);
      tick();
      drive(3'd0, 32'd0, 32'd0, 1'b1);
      for (int i = 1; i <= MULT_N; i++) begin
         check("mult_busy", 32'(busy), 32'd1);
         check("mult_stall", 32'(stall), 32'd1);
         tick();
      end
      check("mult_busy_end", 32'(busy), 32'd0);
      check("mult_stall_end", 32'(stall), 32'd0);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFF4);
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      tick();

      run_op("divu", 3'd4, 32'd100, 32'd7, DIV_N);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, DIV_N);
      check("div_lo", lo, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);

      drive(3'd5, 32'h1234, 32'd0, 1'b0);
      tick();
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      check("mthi_hi", hi, 32'h1234);
      check("mthi_busy", 32'(busy), 32'd0);
      tick();

      run_op("divzero", 3'd3, 32'd55, 32'd0, DIV_N);
      check("divzero_hi", hi, 32'h1234);
      check("divzero_lo", lo, 32'hFFFFFFFD);

      run_op("minint", 3'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N);
      check("minint_lo", lo, 32'h80000000);
      check("minint_hi", hi, 32'd0);

      // reset in cycle t+3 of a divide aborts it
      drive(3'd4, 32'd100, 32'd7, 1'b0);
      tick();
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      for (int i = 0; i < DIV_N + 2; i++) tick();
      check("abort_no_write_hi", hi, 32'd0);
      check("abort_no_write_lo", lo, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 11));
         a1 = 5'($urandom_range(0, 5)); a2 = 5'($urandom_range(0, 5));
         a3_E = 5'($urandom_range(0, 5)); a3_M = 5'($urandom_range(0, 5));
         tuse_rs = 2'($urandom); tuse_rt = 2'($urandom);
         tnew_E = 2'($urandom); tnew_M = 2'($urandom);
         regwrite_E = 1'($urandom); regwrite_M = 1'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         drive((r > 7) ? 3'd0 : 3'(r), pick(), pick(), 1'($urandom));
         tick();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md_hazard_controller.md
Name: md_hazard_controller

Overview:
- Owns the multiply/divide unit and all pipeline stall decisions.
- The MD unit holds the HI/LO registers, a multi-cycle busy counter and the mult/div arithmetic, with operands taken in E stage.
- Stall generation covers two sources:
  - Tuse/Tnew data-hazard stalls for the D stage.
  - Structural stalls for any MD instruction that reaches D while the MD unit is busy or starting.
- Top level uses `stall` to freeze PC and the F/D register and to insert a bubble into D/E. The forwarding logic covers every case this block does not stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- md_op_E  in  3  E-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_val_E  in  32  forwarded rs operand in E
- rt_val_E  in  32  forwarded rt operand in E
- md_use_D  in  1  D-stage instruction is any MD instruction (mult/div/mthi/mtlo/mfhi/mflo)
- a1  in  5  D-stage rs index
- a2  in  5  D-stage rt index
- tuse_rs  in  2  D-stage rs Tuse (3 = not used)
- tuse_rt  in  2  D-stage rt Tuse (3 = not used)
- a3_E  in  5  E-stage destination
- a3_M  in  5  M-stage destination
- tnew_E  in  2  E-stage Tnew
- tnew_M  in  2  M-stage Tnew
- regwrite_E  in  1  E-stage writes GRF
- regwrite_M  in  1  M-stage writes GRF
- hi  out  32  HI register (mfhi source in E)
- lo  out  32  LO register (mflo source in E)
- busy  out  1  MD operation in progress
- stall  out  1  freeze F/D, bubble into E

Behaviour:
- Reset (sync):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0, operand latches=0.
  - Reset mid-operation aborts the operation; the result is never written.
- FSM IDLE/RUN:
  - IDLE with md_op_E in 1..4 (cycle t): latch rs/rt and op, counter=MULT_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: busy=1 (registered, state==RUN), counter decrements each cycle.
  - RUN with counter==1: write hi/lo at that edge and return to IDLE.
  - Timing: busy high in cycles t+1..t+N; new hi/lo visible from cycle t+N+1; busy=0 in t+N+1.
- mthi/mtlo in IDLE: write hi/lo from rs_val_E at the end of the E cycle, no busy.
- Any md_op_E≠0 while RUN is ignored (stall prevents it).
- Arithmetic:
  - mult: signed 32x32→64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32→64; hi=[63:32], lo=[31:0].
  - div/divu: lo=quotient, hi=remainder.
  - Signed div truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
  - Divide by zero: hi/lo unchanged, busy still asserted for DIV_CYCLES.
- Result computation may be combinational from the latched operands at the final edge; it must not be derived from live E inputs after cycle t.
- stall (combinational):
  - stall_rs = a1≠0 && ((regwrite_E && a1==a3_E && tuse_rs<tnew_E) || (regwrite_M && a1==a3_M && tuse_rs<tnew_M))
  - stall_rt = same expression with a2/tuse_rt.
  - stall_md = md_use_D && (busy || md_op_E∈1..4)
  - stall = stall_rs | stall_rt | stall_md
- Simultaneous events: last RUN cycle plus MD instruction in D → stall stays 1 (busy still 1); D proceeds in t+N+1.
- No output depends on an unknown input when reset is high.

Test Plan:
- Reset, then mult rs=3 rt=0xFFFFFFFC → busy=1 in cycles t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFF4, busy=0.
- divu rs=100 rt=7 → busy for 10 cycles, then lo=14, hi=2. div rs=0xFFFFFFF9 (−7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mult starts at t with md_use_D=1 → stall=1 for cycles t..t+5, 0 at t+6.
- Data hazards:
  - a3_E=5, regwrite_E=1, tnew_E=2, a1=5, tuse_rs=0 → stall=1.
  - Same with a1=0 → stall=0.
  - a3_M=5, tnew_M=1, tuse_rs=1 → stall=0.
- mthi rs=0x1234 in IDLE → hi=0x1234 next cycle, busy never asserted; div rt=0 → hi/lo unchanged after 10 busy cycles.
- reset asserted at cycle t+3 of a div → busy=0, hi=lo=0 next cycle; no later write occurs.
